// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

   // Controller states
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Radix-4 Booth digit values
   typedef enum logic [2:0] {
      ZERO,
      POS1,
      POS2,
      NEG1,
      NEG2
   } digit_t;

   // Number of Booth digits retired for a given operand width
   function automatic int unsigned iter_count(input int unsigned width);
      return width / 2 + 1;
   endfunction

   // Map the overlapping triplet {b[2i+1], b[2i], b[2i-1]} to its digit
   function automatic digit_t decode_triplet(input logic [2:0] triplet);
      digit_t d;
      case (triplet)
         3'b001, 3'b010: d = POS1;
         3'b011:         d = POS2;
         3'b100:         d = NEG2;
         3'b101, 3'b110: d = NEG1;
         default:        d = ZERO;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// One Booth digit: selects 0, +-a or +-2a from the extended multiplicand.
// Negative digits come out in one's complement with neg_c as the +1 carry,
// so the accumulator adder absorbs the two's-complement increment.
module booth_r4_digit
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [2:0]       triplet,
   input  logic [WIDTH+1:0] mcand,
   output logic [WIDTH+2:0] pp_c,
   output logic             neg_c
);

   localparam int unsigned PW = WIDTH + 3;

   digit_t          digit;
   logic [PW-1:0]   one_x;
   logic [PW-1:0]   two_x;
   logic [PW-1:0]   mag;

   // Decode the triplet and select the partial-product magnitude and sign
   always_comb begin
      digit = decode_triplet(triplet);
      one_x = {mcand[WIDTH+1], mcand};
      two_x = {mcand, 1'b0};
      mag   = '0;
      neg_c = 1'b0;
      case (digit)
         POS1: mag = one_x;
         POS2: mag = two_x;
         NEG1: begin
            mag   = one_x;
            neg_c = 1'b1;
         end
         NEG2: begin
            mag   = two_x;
            neg_c = 1'b1;
         end
         default: mag = '0;
      endcase
      pp_c = neg_c ? ~mag : mag;
   end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier: one digit per enabled cycle, exact
// 2*WIDTH-bit signed or unsigned product, start/busy/done handshake.
// WIDTH must be even and at least 4.
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned EW   = WIDTH + 2;
   localparam int unsigned PW   = WIDTH + 3;
   localparam int unsigned AW   = 2 * WIDTH + 4;
   localparam int unsigned RW   = 2 * WIDTH;
   localparam int unsigned N    = iter_count(WIDTH);
   localparam int unsigned CW   = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          state;
   logic [EW-1:0]   a_ext;
   logic [EW-1:0]   b_ext;
   logic [EW-1:0]   mcand;
   logic [EW-1:0]   mplier;
   logic            b_prev;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   pp_ext;
   logic [AW-1:0]   addend;
   logic [AW-1:0]   carry;
   logic [AW-1:0]   sum;
   logic [AW-1:0]   acc_next;
   logic [PW-1:0]   pp;
   logic            neg;

   // Extend operands to WIDTH+2 bits so unsigned inputs need no special case
   always_comb begin
      a_ext = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
      b_ext = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
   end

   booth_r4_digit #(
      .WIDTH (WIDTH)
   ) u_digit (
      .triplet ({mplier[1:0], b_prev}),
      .mcand   (mcand),
      .pp_c    (pp),
      .neg_c   (neg)
   );

   // Add the digit's partial product at the top, then shift right by one digit;
   // after N steps the lowest digit has landed at bit 0 with nothing lost.
   always_comb begin
      pp_ext   = {{(AW - PW){pp[PW-1]}}, pp};
      addend   = pp_ext << (WIDTH + 2);
      carry    = AW'(neg) << (WIDTH + 2);
      sum      = acc + addend + carry;
      acc_next = {{2{sum[AW-1]}}, sum[AW-1:2]};
   end

   // Controller, digit counter, accumulator and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         b_prev  <= 1'b0;
         cnt     <= '0;
         acc     <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mcand   <= a_ext;
                  mplier  <= b_ext;
                  b_prev  <= 1'b0;
                  cnt     <= '0;
                  acc     <= '0;
                  product <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_next;
               mplier <= {2'b00, mplier[EW-1:2]};
               b_prev <= mplier[1];
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  product <= acc_next[RW-1:0];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// Self-checking bench for booth_r4_seq_mult at WIDTH=8 and WIDTH=16.
module tb_booth_r4_seq_mult;

   localparam int N8  = 8 / 2 + 1;
   localparam int N16 = 16 / 2 + 1;

   logic        clk;
   logic        rst_n;
   logic        ena;

   logic        start8, sm8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] product8;

   logic        start16, sm16, busy16, done16;
   logic [15:0] a16, b16;
   logic [31:0] product16;

   int tests = 0;
   int fails = 0;

   booth_r4_seq_mult #(.WIDTH(8)) dut8 (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .start       (start8),
      .signed_mode (sm8),
      .a           (a8),
      .b           (b8),
      .busy        (busy8),
      .done        (done8),
      .product     (product8)
   );

   booth_r4_seq_mult #(.WIDTH(16)) dut16 (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .start       (start16),
      .signed_mode (sm16),
      .a           (a16),
      .b           (b16),
      .busy        (busy16),
      .done        (done16),
      .product     (product16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Plain-arithmetic reference: interpret operands, multiply, keep 2*w bits
   function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input bit sm);
      longint sx, sy, m;
      sx = longint'(x);
      sy = longint'(y);
      if (sm && x[w-1]) sx = sx - (longint'(1) << w);
      if (sm && y[w-1]) sy = sy - (longint'(1) << w);
      m = (longint'(1) << (2 * w)) - 1;
      return 64'((sx * sy) & m);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // One 8-bit multiply with optional ena stall and an ignored start while running
   task automatic op8(input string tag, input bit sm, input logic [7:0] x, input logic [7:0] y,
                      input int stall_at, input int stall_len, input int inject_at);
      int cyc;
      int nbusy;
      logic [15:0] expv;
      expv = 16'(ref_mul(8, 32'(x), 32'(y), sm));
      @(negedge clk);
      sm8 = sm; a8 = x; b8 = y; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      check({tag, "_clr"}, 64'(product8), 64'd0);
      cyc   = 0;
      nbusy = (busy8 === 1'b1) ? 1 : 0;
      while (done8 !== 1'b1 && cyc < 64) begin
         if (cyc == stall_at) ena = 1'b0;
         if (cyc == stall_at + stall_len) ena = 1'b1;
         if (cyc == inject_at) begin
            start8 = 1'b1; a8 = 8'd3; b8 = 8'd3; sm8 = 1'b0;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
         cyc++;
         if (busy8 === 1'b1) nbusy++;
      end
      ena    = 1'b1;
      start8 = 1'b0;
      check({tag, "_lat"},  64'(cyc),      64'(N8 + stall_len));
      check({tag, "_busy"}, 64'(nbusy),    64'(N8 + stall_len));
      check({tag, "_prod"}, 64'(product8), 64'(expv));
      @(negedge clk);
      check({tag, "_pulse"}, 64'({busy8, done8}), 64'd0);
   endtask

   // One 16-bit multiply
   task automatic op16(input string tag, input bit sm, input logic [15:0] x, input logic [15:0] y);
      int cyc;
      logic [31:0] expv;
      expv = 32'(ref_mul(16, 32'(x), 32'(y), sm));
      @(negedge clk);
      sm16 = sm; a16 = x; b16 = y; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      cyc = 0;
      while (done16 !== 1'b1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"},  64'(cyc),       64'(N16));
      check({tag, "_prod"}, 64'(product16), 64'(expv));
      @(negedge clk);
      check({tag, "_pulse"}, 64'({busy16, done16}), 64'd0);
   endtask

   initial begin
      int extra;
      bit s;
      rst_n = 1'b0; ena = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      repeat (2) @(negedge clk);
      check("rst8",  64'({busy8, done8, product8}),    64'd0);
      check("rst16", 64'({busy16, done16, product16}), 64'd0);
      rst_n = 1'b1;

      // Start with ena low must not be taken
      @(negedge clk);
      ena = 1'b0; a8 = 8'd5; b8 = 8'd5; start8 = 1'b1;
      repeat (2) @(negedge clk);
      check("ena_off_start", 64'(busy8), 64'd0);
      start8 = 1'b0; ena = 1'b1;

      op8("umax", 1'b0, 8'hFF, 8'hFF, -1, 0, -1);
      check("umax_const", 64'(product8), 64'h FE01);
      op8("s_min_min", 1'b1, 8'h80, 8'h80, -1, 0, -1);
      check("s_min_min_const", 64'(product8), 64'h4000);
      op8("s_min_max", 1'b1, 8'h80, 8'h7F, -1, 0, -1);
      check("s_min_max_const", 64'(product8), 64'hC080);
      op8("s_m1_p1", 1'b1, 8'hFF, 8'h01, -1, 0, -1);
      check("s_m1_p1_const", 64'(product8), 64'hFFFF);
      op8("s_zero", 1'b1, 8'h00, 8'hB3, -1, 0, -1);
      check("s_zero_const", 64'(product8), 64'h0000);

      // Second start two cycles into a 7x9 run is ignored
      op8("busy_start", 1'b0, 8'd7, 8'd9, -1, 0, 2);
      check("busy_start_const", 64'(product8), 64'd63);
      extra = 0;
      repeat (2 * N8) begin
         @(negedge clk);
         if (done8 === 1'b1 || busy8 === 1'b1) extra++;
      end
      check("busy_start_no_second", 64'(extra), 64'd0);

      // Three-cycle ena stall mid-run
      op8("stall", 1'b1, 8'd100, 8'hCE, 2, 3, -1);
      check("stall_const", 64'(product8), 64'hEC78);

      // Asynchronous reset in the middle of a run
      @(negedge clk);
      sm8 = 1'b0; a8 = 8'd7; b8 = 8'd9; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_mid", 64'({busy8, done8, product8}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_idle", 64'({busy8, done8}), 64'd0);
      op8("after_rst", 1'b0, 8'd12, 8'd12, -1, 0, -1);
      check("after_rst_const", 64'(product8), 64'd144);

      op16("s16_min", 1'b1, 16'h8000, 16'h8000);
      check("s16_min_const", 64'(product16), 64'h4000_0000);
      op16("u16_max", 1'b0, 16'hFFFF, 16'hFFFF);
      check("u16_max_const", 64'(product16), 64'hFFFE_0001);

      for (int i = 0; i < 16; i++) begin
         s = 1'($urandom_range(0, 1));
         op8($sformatf("r8_%0d", i), s, 8'($urandom), 8'($urandom), -1, 0, -1);
         s = 1'($urandom_range(0, 1));
         op16($sformatf("r16_%0d", i), s, 16'($urandom), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
